multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and result width; all numbers below assume 32.
REQ-002 clockMul  input  1  sole clock; all state changes on the rising edge.
REQ-003 resetMul  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request; sampled on the rising edge of clockMul.
REQ-005 mult1  input  32  multiplicand, unsigned; sampled only on an accepted start.
REQ-006 mult2  input  32  multiplier, unsigned; sampled only on an accepted start.
REQ-007 done  output  1  registered; high while a valid result is held.
REQ-008 produto  output  32  registered; low 32 bits of mult1*mult2.

Function
REQ-009 The block SHALL be a sequential shift-add multiplier with states IDLE, BUSY, DONE.
REQ-010 IDLE or DONE, start=1 at an edge: load A=mult1 (zero-extended to 64 bits), B=mult2, acc=0, count=0, done=0; go to BUSY.
REQ-011 BUSY, each edge: if B[0]=1 then acc=acc+A (64-bit); A=A<<1; B=B>>1; count=count+1.
REQ-012 BUSY lasts exactly 32 edges; on the 32nd edge the block SHALL set produto=acc_final[31:0] and done=1, and go to DONE.
REQ-013 Latency: with start sampled at edge k, done and the final produto are visible after edge k+32.
REQ-014 start while BUSY SHALL be ignored; the operation in progress completes unchanged.
REQ-015 Changes on mult1/mult2 outside an accepted start SHALL have no effect on the operation or on the held result.
REQ-016 DONE SHALL hold done=1 and produto until the next accepted start or reset.
REQ-017 On a start accepted in DONE, done SHALL fall at that edge; produto keeps the old value until the new result is written.
REQ-018 produto SHALL NOT change during BUSY.
REQ-019 The product is unsigned; bits above 31 are discarded unless REQ-024 applies; there is no overflow flag.
REQ-020 start held high continuously SHALL restart one operation per completion: DONE lasts 1 cycle, then a new BUSY begins.

Reset
REQ-021 resetMul=1 at an edge SHALL force IDLE with done=0, produto=0, and acc, A, B and count cleared.
REQ-022 resetMul SHALL take priority over start, including a reset arriving mid-BUSY, which aborts the operation with no result.
REQ-023 The first edge with resetMul=0 and start=1 SHALL be accepted normally.

Configuration
REQ-024 Macro MULTIPLIER_HI_EN defined: add output produtoHi [31:0] = acc_final[63:32]; it is registered, updated and reset exactly like produto.
REQ-025 Macro MULTIPLIER_HI_EN undefined: port produtoHi is absent and only the low word is produced; behaviour is otherwise identical.

Verification
REQ-026 Reset, then start=1 for one cycle with mult1=5, mult2=6 -> done=0 for 32 edges, then done=1 and produto=30 (0x1E).
REQ-027 After REQ-026 completes, set mult1=10, mult2=20 without start -> produto stays 30 and done stays 1; then pulse start -> produto=200 (0xC8) 32 edges later.
REQ-028 mult1=0xFFFFFFFF, mult2=2 -> produto=0xFFFFFFFE; with MULTIPLIER_HI_EN defined, produtoHi=0x00000001.
REQ-029 Start with 7*9, then pulse start at BUSY cycle 10 with 3*3 -> produto=63 (0x3F) at the original latency, with no restart.
REQ-030 Assert resetMul at BUSY cycle 15 -> next edge done=0, produto=0, state IDLE; a later start with mult1=0, mult2=0x1234 -> produto=0.

Source files
------------

// File: rtl/multiplier_if.sv
// Operand/result bundle for the shift-add multiplier.
// MULTIPLIER_HI_EN adds the produtoHi upper result word.
interface multiplier_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] mult1;
  logic [WIDTH-1:0] mult2;
  logic             done;
  logic [WIDTH-1:0] produto;
`ifdef MULTIPLIER_HI_EN
  logic [WIDTH-1:0] produtoHi;

  modport master (
    output start, mult1, mult2,
    input  done, produto, produtoHi
  );
  modport slave (
    input  start, mult1, mult2,
    output done, produto, produtoHi
  );
`else
  modport master (
    output start, mult1, mult2,
    input  done, produto
  );
  modport slave (
    input  start, mult1, mult2,
    output done, produto
  );
`endif
endinterface

// File: rtl/multiplier.sv
// Sequential shift-add unsigned multiplier, one bit per cycle.
// MULTIPLIER_HI_EN also returns the upper result word.
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic         clockMul,
  input  logic         resetMul,
  multiplier_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  state_t             nstate;
  logic [2*WIDTH-1:0] a;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_add;
  logic [WIDTH-1:0]   b;
  logic [CW-1:0]      cnt;
  logic               load;
  logic               last;
  logic               done_q;
  logic [WIDTH-1:0]   lo_q;
`ifdef MULTIPLIER_HI_EN
  logic [WIDTH-1:0]   hi_q;
`endif

  assign acc_add = acc + (b[0] ? a : '0);

  // Next state: accept start when idle/done, finish after WIDTH steps
  always_comb begin
    nstate = state;
    load   = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load   = 1'b1;
          nstate = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last   = 1'b1;
          nstate = DONE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clockMul) begin
    if (resetMul) state <= IDLE;
    else          state <= nstate;
  end

  // Datapath: operand load, shift-add steps, result capture
  always_ff @(posedge clockMul) begin
    if (resetMul) begin
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      lo_q   <= '0;
`ifdef MULTIPLIER_HI_EN
      hi_q   <= '0;
`endif
    end else if (load) begin
      a      <= {{WIDTH{1'b0}}, bus.mult1};
      b      <= bus.mult2;
      acc    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (state == BUSY) begin
      acc <= acc_add;
      a   <= a << 1;
      b   <= b >> 1;
      cnt <= cnt + CW'(1);
      if (last) begin
        done_q <= 1'b1;
        lo_q   <= acc_add[WIDTH-1:0];
`ifdef MULTIPLIER_HI_EN
        hi_q   <= acc_add[2*WIDTH-1:WIDTH];
`endif
      end
    end
  end

  assign bus.done    = done_q;
  assign bus.produto = lo_q;
`ifdef MULTIPLIER_HI_EN
  assign bus.produtoHi = hi_q;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier against a plain-arithmetic model.
// Build with MULTIPLIER_HI_EN to also check produtoHi.
module tb_multiplier;

  logic clockMul = 1'b0;
  logic resetMul = 1'b1;

  multiplier_if #(.WIDTH(32)) bus ();

  multiplier #(.WIDTH(32)) dut (
    .clockMul (clockMul),
    .resetMul (resetMul),
    .bus      (bus.slave)
  );

  always #5 clockMul = ~clockMul;

  int errors = 0;
  int checks = 0;

  // Model of the held result
  logic [31:0] exp_lo = '0;
  logic [31:0] exp_hi = '0;

  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_done);
    check({tag, ".done"}, 64'(bus.done), 64'(exp_done));
    check({tag, ".lo"}, 64'(bus.produto), 64'(exp_lo));
`ifdef MULTIPLIER_HI_EN
    check({tag, ".hi"}, 64'(bus.produtoHi), 64'(exp_hi));
`endif
  endtask

  // Called just after a negedge. Starts a*b; optionally pokes start with
  // other operands mid-operation, scrambles operands, or keeps start high.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input int poke_at, input logic [31:0] px,
                        input logic [31:0] py, input bit scramble,
                        input bit hold, input string tag);
    logic [63:0] p;
    p = ref_mul(x, y);
    bus.start = 1'b1;
    bus.mult1 = x;
    bus.mult2 = y;
    @(negedge clockMul);
    check_out({tag, ".acc"}, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      bus.start = hold;
      if (scramble) begin
        bus.mult1 = $urandom;
        bus.mult2 = $urandom;
      end
      if (i == poke_at) begin
        bus.start = 1'b1;
        bus.mult1 = px;
        bus.mult2 = py;
      end
      if (i == 32 && !hold) bus.start = 1'b0;
      @(negedge clockMul);
      if (i < 32) begin
        check_out({tag, ".busy"}, 1'b0);
      end else begin
        exp_lo = p[31:0];
        exp_hi = p[63:32];
        check_out({tag, ".res"}, 1'b1);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mult1 = '0;
    bus.mult2 = '0;
    resetMul  = 1'b1;
    @(negedge clockMul);
    @(negedge clockMul);
    check_out("reset", 1'b0);

    // Reset released together with start: accepted on that edge
    resetMul = 1'b0;
    run_op(32'd5, 32'd6, 0, '0, '0, 1'b0, 1'b0, "5x6");

    // Operand changes without start leave the held result alone
    bus.mult1 = 32'd10;
    bus.mult2 = 32'd20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clockMul);
      check_out("hold30", 1'b1);
    end
    run_op(32'd10, 32'd20, 0, '0, '0, 1'b0, 1'b0, "10x20");

    run_op(32'hFFFF_FFFF, 32'd2, 0, '0, '0, 1'b0, 1'b0, "max_x2");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, '0, 1'b0, 1'b0,
           "max_max");

    // Start during BUSY is ignored
    run_op(32'd7, 32'd9, 10, 32'd3, 32'd3, 1'b0, 1'b0, "7x9_poke");

    // Start held high: one restart per completion
    run_op(32'h0001_0003, 32'h0002_0005, 0, '0, '0, 1'b0, 1'b1, "held1");
    run_op(32'h0001_0003, 32'h0002_0005, 0, '0, '0, 1'b0, 1'b0, "held2");

    // Reset mid-BUSY aborts the operation
    bus.start = 1'b1;
    bus.mult1 = 32'h1234_5678;
    bus.mult2 = 32'd3;
    @(negedge clockMul);
    bus.start = 1'b0;
    for (int i = 1; i < 15; i++) @(negedge clockMul);
    resetMul = 1'b1;
    @(negedge clockMul);
    exp_lo = '0;
    exp_hi = '0;
    check_out("midrst", 1'b0);
    resetMul = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clockMul);
      check_out("idle", 1'b0);
    end
    run_op(32'd0, 32'h1234, 0, '0, '0, 1'b0, 1'b0, "0x1234");

    // Random operands with disturbances during BUSY
    for (int n = 0; n < 8; n++) begin
      run_op($urandom, $urandom, int'($urandom_range(1, 31)),
             $urandom, $urandom, 1'b1, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
